riscv_32f_issue_ctrl: RTL and testbench

Sequencing stage directly upstream of the pipelined RV32F ALU, which has fixed-latency vendor FP cores and a combinational stall request. It decodes each issued FP instruction into a cycle latency and holds the integer pipeline stalled for exactly that many cycles. It then captures the ALU output into a registered result for writeback and pulses a valid strobe. It also counts FP stall cycles for performance monitoring.

---
 rtl/riscv_32f_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_riscv_32f_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_32f_issue_ctrl.sv
// Issue sequencer for the pipelined RV32F ALU: stalls the integer pipe for the
// decoded fixed latency of each FP op, captures the result and strobes it to writeback.
module riscv_32f_issue_ctrl #(
    parameter int unsigned LAT_ADD     = 7,
    parameter int unsigned LAT_MUL     = 5,
    parameter int unsigned LAT_FMA     = 12,
    parameter int unsigned LAT_DIV     = 16,
    parameter int unsigned LAT_SQRT    = 16,
    parameter int unsigned LAT_CMP     = 3,
    parameter int unsigned LAT_CVT     = 6,
    parameter int unsigned LAT_DEFAULT = 16,
    parameter int unsigned CW          = 6,
    parameter logic [15:0] ENCODING_FARITH = 16'h0001,
    parameter logic [15:0] ENCODING_FMADD  = 16'h0002,
    parameter logic [15:0] ENCODING_FMSUB  = 16'h0004,
    parameter logic [15:0] ENCODING_FNMSUB = 16'h0008,
    parameter logic [15:0] ENCODING_FNMADD = 16'h0010
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        issue_i,
    input  logic        flush_i,
    input  logic [15:0] encoding_i,
    input  logic [4:0]  func5_i,
    input  logic        stall_req_i,
    input  logic [31:0] alu_result_i,
    output logic        stall_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic        busy_o,
    output logic [31:0] stall_cycles_o
);

    localparam logic [4:0] F5_ADD      = 5'b00000;
    localparam logic [4:0] F5_SUB      = 5'b00001;
    localparam logic [4:0] F5_MUL      = 5'b00010;
    localparam logic [4:0] F5_DIV      = 5'b00011;
    localparam logic [4:0] F5_SQRT     = 5'b01011;
    localparam logic [4:0] F5_MIN_MAX  = 5'b00101;
    localparam logic [4:0] F5_CMP      = 5'b10100;
    localparam logic [4:0] F5_FCVT_FTI = 5'b11000;
    localparam logic [4:0] F5_FCVT_ITF = 5'b11010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic [31:0]     captured;
    logic [CW-1:0]   lat_sel;
    logic            start_c;
    logic            bypass_c;

    // Latency decode of the op currently presented to the ALU
    always_comb begin
        lat_sel = CW'(LAT_DEFAULT);
        if (encoding_i == ENCODING_FMADD || encoding_i == ENCODING_FMSUB ||
            encoding_i == ENCODING_FNMADD || encoding_i == ENCODING_FNMSUB) begin
            lat_sel = CW'(LAT_FMA);
        end else if (encoding_i == ENCODING_FARITH) begin
            case (func5_i)
                F5_ADD, F5_SUB:           lat_sel = CW'(LAT_ADD);
                F5_MUL:                   lat_sel = CW'(LAT_MUL);
                F5_DIV:                   lat_sel = CW'(LAT_DIV);
                F5_SQRT:                  lat_sel = CW'(LAT_SQRT);
                F5_CMP, F5_MIN_MAX:       lat_sel = CW'(LAT_CMP);
                F5_FCVT_FTI, F5_FCVT_ITF: lat_sel = CW'(LAT_CVT);
                default:                  lat_sel = CW'(LAT_DEFAULT);
            endcase
        end
    end

    // Issue-cycle decisions; flush suppresses both the start and the bypass
    assign start_c  = (state == IDLE) && issue_i && stall_req_i && !flush_i;
    assign bypass_c = (state == IDLE) && issue_i && !stall_req_i && !flush_i;

    assign stall_o        = start_c || (state == COUNT);
    assign result_valid_o = bypass_c || ((state == DONE) && !flush_i);
    assign result_o       = (state == DONE) ? captured : alu_result_i;
    assign busy_o         = (state != IDLE);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state          <= IDLE;
            counter        <= '0;
            captured       <= '0;
            stall_cycles_o <= '0;
        end else begin
            if (stall_o && (stall_cycles_o != 32'hFFFF_FFFF)) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        counter <= '0;
                    end else if (start_c) begin
                        counter <= lat_sel - CW'(1);
                        state   <= COUNT;
                    end
                end
                COUNT: begin
                    if (flush_i) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else if (counter != '0) begin
                        counter <= counter - CW'(1);
                    end else begin
                        captured <= alu_result_i;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    counter <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_32f_issue_ctrl.sv
// Randomized scoreboard bench for riscv_32f_issue_ctrl against a transaction-level
// model of per-op latency, stall windows, flush/reset aborts and the stall counter.
module tb_riscv_32f_issue_ctrl;

    localparam logic [15:0] ENC_FARITH = 16'h0001;
    localparam logic [15:0] ENC_FMADD  = 16'h0002;
    localparam logic [15:0] ENC_FMSUB  = 16'h0004;
    localparam logic [15:0] ENC_FNMSUB = 16'h0008;
    localparam logic [15:0] ENC_FNMADD = 16'h0010;
    localparam logic [15:0] ENC_FLW    = 16'h0020;
    localparam logic [15:0] ENC_FSW    = 16'h0040;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SUB  = 5'b00001;
    localparam logic [4:0] F5_MUL  = 5'b00010;
    localparam logic [4:0] F5_DIV  = 5'b00011;
    localparam logic [4:0] F5_SQRT = 5'b01011;
    localparam logic [4:0] F5_SGNJ = 5'b00100;
    localparam logic [4:0] F5_MM   = 5'b00101;
    localparam logic [4:0] F5_CMP  = 5'b10100;
    localparam logic [4:0] F5_FTI  = 5'b11000;
    localparam logic [4:0] F5_ITF  = 5'b11010;
    localparam logic [4:0] F5_MVX  = 5'b11100;
    localparam logic [4:0] F5_MVW  = 5'b11110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] enc = ENC_FARITH;
    logic [4:0]  f5 = F5_ADD;
    logic        sreq = 1'b0;
    logic [31:0] alu = 32'h0;
    logic        stall;
    logic [31:0] result;
    logic        rvalid;
    logic        busy;
    logic [31:0] scnt;

    riscv_32f_issue_ctrl dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .issue_i       (issue),
        .flush_i       (flush),
        .encoding_i    (enc),
        .func5_i       (f5),
        .stall_req_i   (sreq),
        .alu_result_i  (alu),
        .stall_o       (stall),
        .result_o      (result),
        .result_valid_o(rvalid),
        .busy_o        (busy),
        .stall_cycles_o(scnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        int          idx;
        bit          e_stall;
        bit          e_valid;
        bit          e_busy;
        bit          chk_res;
        logic [31:0] e_res;
        logic [31:0] e_scnt;
    } cyc_t;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } res_t;

    cyc_t        cq[$];
    res_t        rq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          mon_idx = 0;
    logic [31:0] model_scnt = 32'h0;
    bit          prev_stall = 1'b0;
    bit          prev_rst = 1'b1;

    logic [15:0] enc_tab[7] = '{ENC_FARITH, ENC_FMADD, ENC_FMSUB, ENC_FNMSUB,
                                ENC_FNMADD, ENC_FLW, ENC_FSW};
    logic [4:0]  f5_tab[12] = '{F5_ADD, F5_SUB, F5_MUL, F5_DIV, F5_SQRT, F5_SGNJ,
                               F5_MM, F5_CMP, F5_FTI, F5_ITF, F5_MVX, F5_MVW};

    // Spec latency table
    function automatic int lat_of(input logic [15:0] e, input logic [4:0] f);
        if (e == ENC_FMADD || e == ENC_FMSUB || e == ENC_FNMADD || e == ENC_FNMSUB)
            return 12;
        if (e != ENC_FARITH) return 16;
        case (f)
            F5_ADD, F5_SUB: return 7;
            F5_MUL:         return 5;
            F5_DIV:         return 16;
            F5_SQRT:        return 16;
            F5_CMP, F5_MM:  return 3;
            F5_FTI, F5_ITF: return 6;
            default:        return 16;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, mon_idx, act, exp);
        end
    endtask

    // One clock of stimulus plus the model's expectation for that cycle
    task automatic step(input bit r, input bit iss, input bit fl, input logic [15:0] e,
                        input logic [4:0] f, input bit sr, input logic [31:0] a,
                        input bit chk, input bit es, input bit ev, input bit eb,
                        input bit cr, input logic [31:0] er);
        cyc_t c;
        @(posedge clk);
        if (prev_rst) model_scnt = 32'h0;
        else if (prev_stall && model_scnt != 32'hFFFF_FFFF) model_scnt = model_scnt + 32'd1;
        #1;
        rst = r; issue = iss; flush = fl; enc = e; f5 = f; sreq = sr; alu = a;
        c.chk = chk; c.idx = cyc_n; c.e_stall = es; c.e_valid = ev; c.e_busy = eb;
        c.chk_res = cr; c.e_res = er; c.e_scnt = model_scnt;
        cq.push_back(c);
        if (chk && ev) rq.push_back('{idx: cyc_n, val: er});
        prev_stall = es;
        prev_rst = r;
        cyc_n++;
    endtask

    task automatic idle();
        logic [31:0] a;
        a = $urandom;
        step(1'b0, 1'b0, 1'b0, enc_tab[$urandom_range(0, 6)], f5_tab[$urandom_range(0, 11)],
             1'($urandom), a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a);
    endtask

    // One instruction: fl_at/rs_at give the op-relative cycle of a flush/reset (-1 none)
    task automatic run_op(input logic [15:0] e, input logic [4:0] f, input bit sr,
                          input logic [31:0] val, input bit scramble,
                          input int fl_at, input int rs_at);
        int L;
        logic [31:0] a;
        logic [15:0] ek;
        bit fl, r;
        if (!sr) begin
            fl = (fl_at == 0);
            step(1'b0, 1'b1, fl, e, f, 1'b0, val, 1'b1, 1'b0, !fl, 1'b0, 1'b1, val);
            return;
        end
        L = lat_of(e, f);
        for (int k = 0; k <= L + 1; k++) begin
            a  = (k >= L) ? val : $urandom;
            ek = (scramble && k >= 1 && k <= L) ? enc_tab[$urandom_range(0, 6)] : e;
            fl = (k == fl_at);
            r  = (k == rs_at);
            if (fl && k == 0) begin
                step(1'b0, 1'b1, 1'b1, e, f, 1'b1, a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, a);
                return;
            end
            step(r, 1'b1, fl, ek, f, (k <= L), a, 1'b1, (k <= L), (k == L + 1) && !fl,
                 (k >= 1), (k == 0) || ((k == L + 1) && !fl), (k == 0) ? a : val);
            if (fl || r) return;
        end
    endtask

    // Monitor: per-cycle output checks, result scoreboard popped on each valid strobe
    initial begin
        cyc_t c;
        res_t rx;
        forever begin
            @(negedge clk);
            if (cq.size() != 0) begin
                c = cq.pop_front();
                mon_idx = c.idx;
                if (c.chk) begin
                    cmp("stall_o", 32'(stall), 32'(c.e_stall));
                    cmp("result_valid_o", 32'(rvalid), 32'(c.e_valid));
                    cmp("busy_o", 32'(busy), 32'(c.e_busy));
                    cmp("stall_cycles_o", scnt, c.e_scnt);
                    if (c.chk_res) cmp("result_o", result, c.e_res);
                    if (rvalid === 1'b1) begin
                        if (rq.size() == 0) begin
                            cmp("unexpected_valid", 32'(rvalid), 32'd0);
                        end else begin
                            rx = rq.pop_front();
                            cmp("result_cycle", 32'(c.idx), 32'(rx.idx));
                            cmp("result_value", result, rx.val);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int L, fa, ra, ei, fi;
        bit sr;
        step(1'b1, 1'b0, 1'b0, ENC_FARITH, F5_ADD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, ENC_FARITH, F5_ADD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        // Directed scenarios
        run_op(ENC_FARITH, F5_MUL, 1'b1, 32'h40C0_0000, 1'b0, -1, -1);
        idle();
        run_op(ENC_FARITH, F5_SGNJ, 1'b0, 32'hBF80_0000, 1'b0, -1, -1);
        idle();
        run_op(ENC_FMADD, F5_ADD, 1'b1, 32'h1234_5678, 1'b1, -1, -1);
        idle();
        run_op(ENC_FARITH, F5_DIV, 1'b1, 32'hDEAD_BEEF, 1'b0, 4, -1);
        idle();
        run_op(ENC_FARITH, F5_SQRT, 1'b1, 32'hCAFE_F00D, 1'b0, -1, 3);
        idle();
        run_op(ENC_FARITH, F5_ADD, 1'b1, 32'h3F80_0000, 1'b0, -1, -1);
        run_op(ENC_FARITH, F5_CMP, 1'b1, 32'h0000_0001, 1'b0, -1, -1);
        run_op(ENC_FARITH, F5_CMP, 1'b1, 32'h0000_0000, 1'b0, -1, -1);
        idle();
        run_op(ENC_FNMSUB, F5_ADD, 1'b1, 32'hA5A5_5A5A, 1'b0, 13, -1);
        idle();
        run_op(ENC_FARITH, F5_FTI, 1'b1, 32'h7777_0000, 1'b0, 0, -1);
        run_op(ENC_FARITH, F5_ADD, 1'b0, 32'h5555_AAAA, 1'b0, 0, -1);
        // Randomized traffic, back-to-back or with gaps
        for (int i = 0; i < 200; i++) begin
            ei = $urandom_range(0, 6);
            fi = $urandom_range(0, 11);
            sr = ($urandom_range(0, 4) != 0);
            L  = lat_of(enc_tab[ei], f5_tab[fi]);
            fa = ($urandom_range(0, 99) < 15) ? int'($urandom_range(0, L + 1)) : -1;
            ra = (fa < 0 && $urandom_range(0, 99) < 6) ? int'($urandom_range(1, L)) : -1;
            run_op(enc_tab[ei], f5_tab[fi], sr, $urandom, 1'($urandom), fa, ra);
            repeat ($urandom_range(0, 2)) idle();
        end
        idle();
        idle();
        repeat (2) @(posedge clk);
        #1;
        cmp("results_drained", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
